// File: rtl/chip8_selftest_pkg.sv
// chip8_selftest_pkg
// Shared definitions for the CHIP-8 hardware self-test sequencer:
//   state_t   - sequencer FSM states
//   result_t  - result codes reported on the 'result' output
//   DEF_LOAD_BASE - default program load address / initial PC
//   slot_bits - width of a check-slot index for a given slot count
package chip8_selftest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLR_MEM = 3'd1,
    ST_CLR_REG = 3'd2,
    ST_LOAD    = 3'd3,
    ST_LAUNCH  = 3'd4,
    ST_RUN     = 3'd5,
    ST_CHECK   = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    RES_PASS     = 2'd0,
    RES_TIMEOUT  = 2'd1,
    RES_MISMATCH = 2'd2,
    RES_BADLEN   = 2'd3
  } result_t;

  localparam int DEF_LOAD_BASE = 'h200;

  // A single slot still needs a one-bit index to keep port widths legal.
  function automatic int slot_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chip8_selftest_if.sv
// chip8_selftest_if
// Bundle of everything the self-test sequencer drives into / reads from the
// CPU and the test ROM.
//   prog_addr / prog_data         test-ROM read (data one cycle after address)
//   mem_we / mem_addr / mem_wdata CPU memory write port
//   reg_we / reg_idx / reg_wdata  V-register write port
//   reg_ridx / reg_rdata          V-register read port (combinational data)
//   cpu_hold, pc_load, pc_value   CPU control
//   cpu_idle                      CPU has reached its idle state
// master = sequencer side, slave = CPU / ROM side.
interface chip8_selftest_if #(
  parameter int ADDR_W = 12
);

  logic [ADDR_W-1:0] prog_addr;
  logic [7:0]        prog_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              reg_we;
  logic [3:0]        reg_idx;
  logic [7:0]        reg_wdata;
  logic [3:0]        reg_ridx;
  logic [7:0]        reg_rdata;
  logic              cpu_hold;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_value;
  logic              cpu_idle;

  modport master (
    output prog_addr, mem_we, mem_addr, mem_wdata,
           reg_we, reg_idx, reg_wdata, reg_ridx,
           cpu_hold, pc_load, pc_value,
    input  prog_data, reg_rdata, cpu_idle
  );

  modport slave (
    input  prog_addr, mem_we, mem_addr, mem_wdata,
           reg_we, reg_idx, reg_wdata, reg_ridx,
           cpu_hold, pc_load, pc_value,
    output prog_data, reg_rdata, cpu_idle
  );

endinterface

// File: rtl/chip8_selftest_check.sv
// chip8_selftest_check
// Slot-scan comparator. While 'active' it visits one check slot per cycle in
// index order, reading the V register named by the slot and comparing it with
// the slot's expected value. Disabled slots still take their cycle.
//   clk, reset       clock, synchronous active-high reset
//   clear            restart the scan and clear the mismatch latch
//   active           scan one slot this cycle
//   chk_en/reg/val   latched slot configuration
//   reg_ridx         V-register read index (0 while inactive)
//   reg_rdata        combinational V-register data
//   mismatch         current slot is enabled and differs
//   last             current slot is the final one
//   fail_slot/got/exp  first failing slot, as latched
module chip8_selftest_check
  import chip8_selftest_pkg::*;
#(
  parameter  int NUM_CHECKS = 4,
  localparam int SLOT_W     = slot_bits(NUM_CHECKS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    active,
  input  logic [NUM_CHECKS-1:0]   chk_en,
  input  logic [4*NUM_CHECKS-1:0] chk_reg,
  input  logic [8*NUM_CHECKS-1:0] chk_val,
  output logic [3:0]              reg_ridx,
  input  logic [7:0]              reg_rdata,
  output logic                    mismatch,
  output logic                    last,
  output logic [SLOT_W-1:0]       fail_slot,
  output logic [7:0]              fail_got,
  output logic [7:0]              fail_exp
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CHECKS - 1);

  logic [SLOT_W-1:0] idx;
  logic              cur_en;
  logic [3:0]        cur_reg;
  logic [7:0]        cur_exp;
  int                sel;

  // Decode the slot under the index counter and compare it.
  always_comb begin
    sel      = int'(idx);
    cur_en   = chk_en[sel];
    cur_reg  = chk_reg[4*sel +: 4];
    cur_exp  = chk_val[8*sel +: 8];
    reg_ridx = active ? cur_reg : 4'd0;
    mismatch = active && cur_en && (reg_rdata != cur_exp);
    last     = active && (idx == LAST_SLOT);
  end

  // Index counter plus latch of the first mismatch; the top stops the scan
  // on a mismatch so only the first failing slot is ever captured.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx       <= '0;
      fail_slot <= '0;
      fail_got  <= 8'd0;
      fail_exp  <= 8'd0;
    end else if (active) begin
      if (mismatch) begin
        fail_slot <= idx;
        fail_got  <= reg_rdata;
        fail_exp  <= cur_exp;
      end
      idx <= last ? '0 : idx + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/chip8_selftest.sv
// chip8_selftest
// Hardware self-test sequencer for the CHIP-8 CPU. On 'start' it clears CPU
// memory and V registers, copies a program from the test ROM to LOAD_BASE,
// loads the PC, releases the CPU, waits for idle or a timeout and finally
// checks up to NUM_CHECKS V registers against expected values.
//   clk, reset                 clock, synchronous active-high reset
//   start                      begin a test (accepted in IDLE or DONE)
//   prog_len                   program length in bytes
//   chk_en / chk_reg / chk_val per-slot enable, V index and expected value
//   bus                        CPU / test-ROM side (chip8_selftest_if.master)
//   busy, done, pass           status
//   result                     0 pass, 1 timeout, 2 mismatch, 3 bad length
//   fail_slot/got/exp          first failing check slot
module chip8_selftest
  import chip8_selftest_pkg::*;
#(
  parameter  int ADDR_W     = 12,
  parameter  int MEM_DEPTH  = 4096,
  parameter  int LOAD_BASE  = DEF_LOAD_BASE,
  parameter  int NUM_REGS   = 16,
  parameter  int NUM_CHECKS = 4,
  parameter  int TIMEOUT    = 2**20,
  localparam int SLOT_W     = slot_bits(NUM_CHECKS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       prog_len,
  input  logic [NUM_CHECKS-1:0]   chk_en,
  input  logic [4*NUM_CHECKS-1:0] chk_reg,
  input  logic [8*NUM_CHECKS-1:0] chk_val,
  chip8_selftest_if.master        bus,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [1:0]              result,
  output logic [SLOT_W-1:0]       fail_slot,
  output logic [7:0]              fail_got,
  output logic [7:0]              fail_exp
);

  localparam int RUN_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(LOAD_BASE);
  localparam logic [ADDR_W:0]   MAX_LEN  = (ADDR_W+1)'(MEM_DEPTH - LOAD_BASE);
  localparam logic [ADDR_W:0]   MEM_LAST = (ADDR_W+1)'(MEM_DEPTH - 1);
  localparam logic [ADDR_W:0]   REG_LAST = (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(TIMEOUT - 1);

  state_t state, state_n;

  logic [ADDR_W:0]         cnt;
  logic [RUN_W-1:0]        run_cnt;
  logic                    ld_valid;
  logic [ADDR_W-1:0]       ld_off;
  logic [ADDR_W-1:0]       len_q;
  logic [NUM_CHECKS-1:0]   chk_en_q;
  logic [4*NUM_CHECKS-1:0] chk_reg_q;
  logic [8*NUM_CHECKS-1:0] chk_val_q;

  logic accept;
  logic bad_len;
  logic ck_active;
  logic ck_mismatch;
  logic ck_last;

  chip8_selftest_check #(
    .NUM_CHECKS (NUM_CHECKS)
  ) u_check (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .active    (ck_active),
    .chk_en    (chk_en_q),
    .chk_reg   (chk_reg_q),
    .chk_val   (chk_val_q),
    .reg_ridx  (bus.reg_ridx),
    .reg_rdata (bus.reg_rdata),
    .mismatch  (ck_mismatch),
    .last      (ck_last),
    .fail_slot (fail_slot),
    .fail_got  (fail_got),
    .fail_exp  (fail_exp)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state logic and all per-state outputs. The write ports are only
  // ever driven from CLR_MEM, CLR_REG and LOAD.
  always_comb begin
    state_n       = state;
    accept        = 1'b0;
    bad_len       = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    ck_active     = 1'b0;
    bus.cpu_hold  = 1'b1;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 8'd0;
    bus.reg_we    = 1'b0;
    bus.reg_idx   = 4'd0;
    bus.reg_wdata = 8'd0;
    bus.prog_addr = '0;
    bus.pc_load   = 1'b0;
    bus.pc_value  = '0;

    case (state)
      ST_IDLE, ST_DONE: begin
        done = (state == ST_DONE);
        if (start) begin
          accept = 1'b1;
          if ({1'b0, prog_len} > MAX_LEN) begin
            bad_len = 1'b1;
            state_n = ST_DONE;
          end else begin
            state_n = ST_CLR_MEM;
          end
        end
      end
      ST_CLR_MEM: begin
        busy         = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = cnt[ADDR_W-1:0];
        if (cnt == MEM_LAST) state_n = ST_CLR_REG;
      end
      ST_CLR_REG: begin
        busy        = 1'b1;
        bus.reg_we  = 1'b1;
        bus.reg_idx = cnt[3:0];
        if (cnt == REG_LAST) state_n = (len_q == '0) ? ST_LAUNCH : ST_LOAD;
      end
      ST_LOAD: begin
        // Addresses go out while cnt < len; each byte is written the cycle
        // after its address, so LOAD runs one cycle past the last issue.
        busy = 1'b1;
        if (cnt < {1'b0, len_q}) bus.prog_addr = cnt[ADDR_W-1:0];
        if (ld_valid) begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = BASE_A + ld_off;
          bus.mem_wdata = bus.prog_data;
        end
        if (cnt == {1'b0, len_q}) state_n = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        busy         = 1'b1;
        bus.pc_load  = 1'b1;
        bus.pc_value = BASE_A;
        state_n      = ST_RUN;
      end
      ST_RUN: begin
        // cpu_idle may still reflect the previous run in the first cycle.
        busy         = 1'b1;
        bus.cpu_hold = 1'b0;
        if ((run_cnt != '0) && bus.cpu_idle) state_n = ST_CHECK;
        else if (run_cnt == RUN_LAST)        state_n = ST_DONE;
      end
      ST_CHECK: begin
        busy         = 1'b1;
        bus.cpu_hold = 1'b0;
        ck_active    = 1'b1;
        if (ck_mismatch || ck_last) state_n = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Counters, ROM pipeline register, latched test configuration and the
  // result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      run_cnt   <= '0;
      ld_valid  <= 1'b0;
      ld_off    <= '0;
      len_q     <= '0;
      chk_en_q  <= '0;
      chk_reg_q <= '0;
      chk_val_q <= '0;
      pass      <= 1'b0;
      result    <= RES_PASS;
    end else begin
      if (state_n != state)
        cnt <= '0;
      else if (state inside {ST_CLR_MEM, ST_CLR_REG, ST_LOAD})
        cnt <= cnt + (ADDR_W+1)'(1);

      ld_valid <= (state == ST_LOAD) && (cnt < {1'b0, len_q});
      ld_off   <= cnt[ADDR_W-1:0];

      if (state == ST_RUN) run_cnt <= run_cnt + RUN_W'(1);
      else                 run_cnt <= '0;

      if (accept) begin
        len_q     <= prog_len;
        chk_en_q  <= chk_en;
        chk_reg_q <= chk_reg;
        chk_val_q <= chk_val;
        pass      <= 1'b0;
        result    <= bad_len ? RES_BADLEN : RES_PASS;
      end else if ((state == ST_RUN) && (state_n == ST_DONE)) begin
        result <= RES_TIMEOUT;
      end else if (state == ST_CHECK) begin
        if (ck_mismatch)  result <= RES_MISMATCH;
        else if (ck_last) pass   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chip8_selftest.sv
// tb_chip8_selftest
// Directed bench for chip8_selftest. Around the sequencer sits a test ROM and
// a tiny CHIP-8 core (00E0-style halt on 0000, 00EE, 1NNN, 2NNN, 6XNN, 7XNN)
// so the loaded programs really execute; opcode 0000 halts and raises
// cpu_idle.
module tb_chip8_selftest;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] prog_len;
  logic [3:0]  chk_en;
  logic [15:0] chk_reg;
  logic [31:0] chk_val;
  logic        busy, done, pass;
  logic [1:0]  result;
  logic [1:0]  fail_slot;
  logic [7:0]  fail_got, fail_exp;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;

  chip8_selftest_if #(.ADDR_W(12)) bus ();

  chip8_selftest #(
    .ADDR_W     (12),
    .MEM_DEPTH  (4096),
    .LOAD_BASE  ('h200),
    .NUM_REGS   (16),
    .NUM_CHECKS (4),
    .TIMEOUT    (100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .prog_len  (prog_len),
    .chk_en    (chk_en),
    .chk_reg   (chk_reg),
    .chk_val   (chk_val),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .result    (result),
    .fail_slot (fail_slot),
    .fail_got  (fail_got),
    .fail_exp  (fail_exp)
  );

  always #5 clk = ~clk;

  // Test ROM with one cycle of read latency.
  logic [7:0] rom [0:4095];
  always @(posedge clk) bus.prog_data <= rom[bus.prog_addr];

  // CPU model: memory, V registers, PC/stack; 'poison' fills memory and
  // registers with garbage so clearing can be observed.
  logic [7:0]  cpu_mem [0:4095];
  logic [7:0]  vreg [0:15];
  logic [11:0] stack [0:15];
  logic [11:0] pc = 12'd0;
  logic [3:0]  sp = 4'd0;
  logic        halted = 1'b0;
  logic        poison = 1'b1;
  logic [15:0] op;

  assign op            = {cpu_mem[pc], cpu_mem[pc + 12'd1]};
  assign bus.reg_rdata = vreg[bus.reg_ridx];
  assign bus.cpu_idle  = halted;

  always @(posedge clk) begin
    if (poison) begin
      for (int i = 0; i < 4096; i++) cpu_mem[i] <= 8'hA5;
      for (int i = 0; i < 16; i++)   vreg[i]    <= 8'hA5;
    end else begin
      if (bus.mem_we) cpu_mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.reg_we) vreg[bus.reg_idx]     <= bus.reg_wdata;
      if (bus.cpu_hold) begin
        halted <= 1'b0;
        sp     <= 4'd0;
        if (bus.pc_load) pc <= bus.pc_value;
      end else if (!halted) begin
        case (op[15:12])
          4'h0: begin
            if (op == 16'h00EE) begin
              pc <= stack[sp - 4'd1];
              sp <= sp - 4'd1;
            end else begin
              halted <= 1'b1;
            end
          end
          4'h1: pc <= op[11:0];
          4'h2: begin
            stack[sp] <= pc + 12'd2;
            sp        <= sp + 4'd1;
            pc        <= op[11:0];
          end
          4'h6: begin
            vreg[op[11:8]] <= op[7:0];
            pc             <= pc + 12'd2;
          end
          4'h7: begin
            vreg[op[11:8]] <= vreg[op[11:8]] + op[7:0];
            pc             <= pc + 12'd2;
          end
          default: halted <= 1'b1;
        endcase
      end
    end
  end

  always @(posedge clk) if (bus.mem_we) we_cnt <= we_cnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] len, input logic [3:0] en,
                               input logic [15:0] regs, input logic [31:0] vals);
    prog_len = len;
    chk_en   = en;
    chk_reg  = regs;
    chk_val  = vals;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int limit);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, done, 1);
  endtask

  task automatic clearRom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  // V0=0x10; jump over a V0=0xFF; V0+=0x32 -> 0x42; halt
  task automatic loadJump();
    clearRom();
    rom[0] = 8'h60; rom[1]  = 8'h10;
    rom[2] = 8'h12; rom[3]  = 8'h08;
    rom[4] = 8'h60; rom[5]  = 8'hFF;
    rom[8] = 8'h70; rom[9]  = 8'h32;
  endtask

  // call 0x208 (V0=0x40; return); V0+=2 -> 0x42; halt
  task automatic loadCall();
    clearRom();
    rom[0] = 8'h22; rom[1]  = 8'h08;
    rom[2] = 8'h70; rom[3]  = 8'h02;
    rom[8] = 8'h60; rom[9]  = 8'h40;
    rom[10] = 8'h00; rom[11] = 8'hEE;
  endtask

  // jump-to-self at 0x200
  task automatic loadLoop();
    clearRom();
    rom[0] = 8'h12; rom[1] = 8'h00;
  endtask

  initial begin
    int n;
    int nz;
    int we_before;

    reset    = 1'b1;
    start    = 1'b0;
    prog_len = 12'd0;
    chk_en   = 4'd0;
    chk_reg  = 16'd0;
    chk_val  = 32'd0;
    clearRom();
    repeat (3) @(negedge clk);
    poison = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_fail_slot", fail_slot, 0);
    checkOutput("rst_fail_got", fail_got, 0);
    checkOutput("rst_cpu_hold", bus.cpu_hold, 1);
    checkOutput("rst_mem_we", bus.mem_we, 0);
    checkOutput("rst_reg_we", bus.reg_we, 0);
    checkOutput("rst_pc_load", bus.pc_load, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] jump program, expect pass");
    loadJump();
    applyStimulus(12'd12, 4'b0001, 16'h0000, 32'h0000_0042);
    n = 0;
    while (busy && bus.cpu_hold && n < 10000) begin
      n++;
      @(negedge clk);
    end
    checkOutput("latency_to_run", n, 4096 + 16 + 13 + 1);
    waitDone("t1_done", 6000);
    checkOutput("t1_pass", pass, 1);
    checkOutput("t1_result", result, 0);
    checkOutput("t1_busy", busy, 0);
    checkOutput("t1_hold", bus.cpu_hold, 1);
    checkOutput("t1_loaded", cpu_mem[12'h208], 8'h70);

    $display("[TB] jump program, expect mismatch in slot 0");
    applyStimulus(12'd12, 4'b0001, 16'h0000, 32'h0000_0041);
    checkOutput("t2_done_cleared", done, 0);
    waitDone("t2_done", 6000);
    checkOutput("t2_result", result, 2);
    checkOutput("t2_pass", pass, 0);
    checkOutput("t2_fail_slot", fail_slot, 0);
    checkOutput("t2_fail_got", fail_got, 8'h42);
    checkOutput("t2_fail_exp", fail_exp, 8'h41);

    $display("[TB] disabled slot skipped, mismatch in last slot");
    applyStimulus(12'd12, 4'b1110, 16'h0100, 32'h9900_4200);
    waitDone("t3_done", 6000);
    checkOutput("t3_result", result, 2);
    checkOutput("t3_fail_slot", fail_slot, 3);
    checkOutput("t3_fail_got", fail_got, 8'h42);
    checkOutput("t3_fail_exp", fail_exp, 8'h99);

    $display("[TB] infinite loop, expect timeout");
    loadLoop();
    applyStimulus(12'd2, 4'b0001, 16'h0000, 32'h0000_0000);
    checkOutput("t4_fail_cleared", fail_got, 0);
    n = 0;
    while (!bus.pc_load && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t4_pc_load", bus.pc_load, 1);
    checkOutput("t4_pc_value", bus.pc_value, 12'h200);
    n = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done) break;
      if (!bus.cpu_hold) n++;
    end
    checkOutput("t4_done", done, 1);
    checkOutput("t4_run_cycles", n, 100);
    checkOutput("t4_result", result, 1);
    checkOutput("t4_hold", bus.cpu_hold, 1);
    checkOutput("t4_pass", pass, 0);

    $display("[TB] bad length");
    we_before = we_cnt;
    applyStimulus(12'hE01, 4'b0001, 16'h0000, 32'h0000_0042);
    checkOutput("t5_done", done, 1);
    checkOutput("t5_result", result, 3);
    checkOutput("t5_busy", busy, 0);
    repeat (3) @(negedge clk);
    checkOutput("t5_no_writes", we_cnt - we_before, 0);
    checkOutput("t5_hold", bus.cpu_hold, 1);

    $display("[TB] reset during load, then call program");
    loadCall();
    applyStimulus(12'hE00, 4'b0001, 16'h0000, 32'h0000_0042);
    checkOutput("t6_len_e00_accepted", busy, 1);
    n = 0;
    while (!(bus.mem_we && bus.mem_addr == 12'h20A) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_reached_load", bus.mem_we, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_mem_we", bus.mem_we, 0);
    checkOutput("t6_rst_hold", bus.cpu_hold, 1);
    checkOutput("t6_rst_prog_addr", bus.prog_addr, 0);
    poison = 1'b1;
    @(negedge clk);
    poison = 1'b0;
    applyStimulus(12'd12, 4'b0001, 16'h0000, 32'h0000_0042);
    waitDone("t6_done", 6000);
    checkOutput("t6_pass", pass, 1);
    checkOutput("t6_result", result, 0);
    nz = 0;
    for (int i = 0; i < 'h200; i++) if (cpu_mem[i] != 8'h00) nz++;
    checkOutput("t6_low_mem_zero", nz, 0);
    checkOutput("t6_loaded", cpu_mem[12'h200], 8'h22);

    $display("[TB] no checks enabled, start while busy ignored");
    applyStimulus(12'd12, 4'b0000, 16'h0000, 32'h0000_0000);
    repeat (20) @(negedge clk);
    prog_len = 12'hE01;
    chk_en   = 4'hF;
    chk_val  = 32'h1234_5678;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    checkOutput("t7_still_busy", busy, 1);
    waitDone("t7_done", 6000);
    checkOutput("t7_pass", pass, 1);
    checkOutput("t7_result", result, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
